// File: rtl/mipi_dsi_rst_monitor.sv
// DSI panel reset-line receiver: synchronises the reset input, measures
// each low pulse in ms, flags short/long pulses and gates LCM init.
module mipi_dsi_rst_monitor #(
  parameter int CLK_DIV       = 10000,
  parameter int MIN_LOW_MS    = 10,
  parameter int MAX_LOW_MS    = 500,
  parameter int POST_DELAY_MS = 120,
  parameter int CNT_W         = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dsi_rst_n_in,
  output logic             rst_active,
  output logic             pulse_done,
  output logic [CNT_W-1:0] low_ms,
  output logic             err_short,
  output logic             err_long,
  output logic             init_ready
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] DIV_LAST =
    PW'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [CNT_W-1:0] MIN_C =
    CNT_W'(MIN_LOW_MS);

  localparam logic [CNT_W-1:0] MAX_C =
    CNT_W'(MAX_LOW_MS);

  localparam logic [CNT_W-1:0] POST_LAST =
    CNT_W'(POST_DELAY_MS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    POST,
    READY
  } state_t;

  state_t state, state_d;

  logic s1, s2, s3;
  logic fall, rise, edge_any, tick;

  logic [PW-1:0]    presc, presc_d;
  logic [CNT_W-1:0] ms_cnt, ms_d;
  logic [CNT_W-1:0] ms_inc, meas;
  logic [CNT_W-1:0] low_ms_d;

  logic act_d, done_d, short_d, long_d, rdy_d;

  assign fall     = s3 & ~s2;
  assign rise     = ~s3 & s2;
  assign edge_any = fall | rise;
  assign tick     = (presc == DIV_LAST);

  assign ms_inc = (ms_cnt == CNT_MAX) ?
                  ms_cnt : ms_cnt + 1'b1;

  // A tick coinciding with the release still
  // completes that millisecond of low time.
  assign meas = tick ? ms_inc : ms_cnt;

  always_comb begin
    presc_d = presc + 1'b1;
    if (edge_any || tick) begin
      presc_d = '0;
    end
  end

  always_comb begin
    state_d  = state;
    ms_d     = ms_cnt;
    low_ms_d = low_ms;
    act_d    = rst_active;
    done_d   = 1'b0;
    short_d  = err_short;
    long_d   = err_long;
    rdy_d    = init_ready;

    if (edge_any) begin
      ms_d = '0;
    end else if (tick &&
                 (state == LOW ||
                  state == POST)) begin
      ms_d = ms_inc;
    end

    unique case (state)
      IDLE: begin
        if (fall) begin
          state_d = LOW;
          act_d   = 1'b1;
          short_d = 1'b0;
          long_d  = 1'b0;
          rdy_d   = 1'b0;
        end
      end
      LOW: begin
        if (tick && ms_inc == MAX_C) begin
          long_d = 1'b1;
        end
        if (rise) begin
          low_ms_d = meas;
          done_d   = 1'b1;
          act_d    = 1'b0;
          if (meas < MIN_C) begin
            short_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = POST;
          end
        end
      end
      POST: begin
        if (fall) begin
          state_d = LOW;
          act_d   = 1'b1;
          short_d = 1'b0;
          long_d  = 1'b0;
          rdy_d   = 1'b0;
        end else if (tick &&
                     ms_cnt == POST_LAST) begin
          state_d = READY;
          rdy_d   = 1'b1;
        end
      end
      READY: begin
        if (fall) begin
          state_d = LOW;
          act_d   = 1'b1;
          short_d = 1'b0;
          long_d  = 1'b0;
          rdy_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= dsi_rst_n_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      presc      <= '0;
      ms_cnt     <= '0;
      low_ms     <= '0;
      rst_active <= 1'b0;
      pulse_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      init_ready <= 1'b0;
    end else begin
      state      <= state_d;
      presc      <= presc_d;
      ms_cnt     <= ms_d;
      low_ms     <= low_ms_d;
      rst_active <= act_d;
      pulse_done <= done_d;
      err_short  <= short_d;
      err_long   <= long_d;
      init_ready <= rdy_d;
    end
  end

endmodule

// File: tb/tb_mipi_dsi_rst_monitor.sv
// Bench for mipi_dsi_rst_monitor: pulse table plus hand sequences,
// pulse results checked against a scoreboard queue on pulse_done.
module tb_mipi_dsi_rst_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       rst_active;
  logic       pulse_done;
  logic [9:0] low_ms;
  logic       err_short;
  logic       err_long;
  logic       init_ready;

  mipi_dsi_rst_monitor #(
    .CLK_DIV      (10),
    .MIN_LOW_MS   (5),
    .MAX_LOW_MS   (20),
    .POST_DELAY_MS(3),
    .CNT_W        (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dsi_rst_n_in(din),
    .rst_active  (rst_active),
    .pulse_done  (pulse_done),
    .low_ms      (low_ms),
    .err_short   (err_short),
    .err_long    (err_long),
    .init_ready  (init_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         act;
    logic [9:0] ms;
    bit         es;
    bit         el;
  } exp_t;

  typedef struct {
    int         low;
    int         gap;
    logic [9:0] ms;
    bit         es;
    bit         el;
    bit         rdy;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[7];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               nm, a, e);
    end
  endtask

  // Pulse monitor: active-time, err_long timing,
  // scoreboard pop and init_ready delay.
  int act_cnt = 0;
  int fa      = 0;
  int age     = 0;
  logic p_act = 0, p_el = 0, p_pd = 0, p_rdy = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      act_cnt = 0;
      fa      = 0;
      age     = 0;
      p_act   = 0;
      p_el    = 0;
      p_pd    = 0;
      p_rdy   = 0;
    end else begin
      if (rst_active) act_cnt++;
      if (rst_active && !p_act) fa = 0;
      else fa++;
      if (err_long && !p_el)
        chk("err_long_delay", fa, 200);
      if (pulse_done) begin
        exp_t e;
        chk("pulse_done_width", 32'(p_pd), 0);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("low_ms", 32'(low_ms), 32'(e.ms));
          chk("err_short", 32'(err_short), 32'(e.es));
          chk("err_long", 32'(err_long), 32'(e.el));
          chk("active_clks", act_cnt, e.act);
        end
        act_cnt = 0;
        age     = 0;
      end else begin
        age++;
      end
      if (init_ready && !p_rdy)
        chk("ready_delay", age, 30);
      p_act = rst_active;
      p_el  = err_long;
      p_pd  = pulse_done;
      p_rdy = init_ready;
    end
  end

  task automatic push(input int a,
                      input logic [9:0] ms,
                      input bit es,
                      input bit el);
    exp_t e;
    e.act = a;
    e.ms  = ms;
    e.es  = es;
    e.el  = el;
    sb.push_back(e);
  endtask

  task automatic low_pulse(input int n,
                           input logic [9:0] ms,
                           input bit es,
                           input bit el);
    @(posedge clk);
    #1 din = 1'b0;
    repeat (n) @(posedge clk);
    #1 din = 1'b1;
    push(n, ms, es, el);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{80,  60,  10'd8,  0, 0, 1};
    tbl[1] = '{35,  500, 10'd3,  1, 0, 0};
    tbl[2] = '{250, 60,  10'd25, 0, 1, 1};
    tbl[3] = '{50,  60,  10'd5,  0, 0, 1};
    tbl[4] = '{45,  500, 10'd4,  1, 0, 0};
    tbl[5] = '{190, 60,  10'd19, 0, 0, 1};
    tbl[6] = '{210, 60,  10'd21, 0, 1, 1};

    rst_n = 1'b0;
    din   = 1'b1;
    wait_clk(3);
    chk("rst_rst_active", 32'(rst_active), 0);
    chk("rst_pulse_done", 32'(pulse_done), 0);
    chk("rst_low_ms", 32'(low_ms), 0);
    chk("rst_err_short", 32'(err_short), 0);
    chk("rst_err_long", 32'(err_long), 0);
    chk("rst_init_ready", 32'(init_ready), 0);
    rst_n = 1'b1;
    wait_clk(1000);
    chk("idle_init_ready", 32'(init_ready), 0);

    for (int i = 0; i < 7; i++) begin
      low_pulse(tbl[i].low, tbl[i].ms,
                tbl[i].es, tbl[i].el);
      wait_clk(tbl[i].gap);
      chk("vec_init_ready", 32'(init_ready),
          32'(tbl[i].rdy));
      chk("vec_err_long", 32'(err_long),
          32'(tbl[i].el));
      chk("vec_rst_active", 32'(rst_active), 0);
    end

    // Re-reset during the post-release settle
    low_pulse(80, 10'd8, 0, 0);
    wait_clk(14);
    din = 1'b0;
    wait_clk(5);
    chk("post_refall_active", 32'(rst_active), 1);
    chk("post_refall_ready", 32'(init_ready), 0);
    repeat (55) @(posedge clk);
    #1 din = 1'b1;
    push(60, 10'd6, 0, 0);
    wait_clk(60);
    chk("post_refall_done", 32'(init_ready), 1);

    // Fall while READY: both outputs flip together
    @(posedge clk);
    #1 din = 1'b0;
    wait_clk(2);
    chk("ready_fall_pre_rdy", 32'(init_ready), 1);
    chk("ready_fall_pre_act", 32'(rst_active), 0);
    wait_clk(1);
    chk("ready_fall_rdy", 32'(init_ready), 0);
    chk("ready_fall_act", 32'(rst_active), 1);
    repeat (97) @(posedge clk);
    #1 din = 1'b1;
    push(100, 10'd10, 0, 0);
    wait_clk(60);
    chk("ready_fall_done", 32'(init_ready), 1);

    // Async reset in the middle of a low pulse
    @(posedge clk);
    #1 din = 1'b0;
    wait_clk(40);
    chk("pre_arst_active", 32'(rst_active), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_rst_active", 32'(rst_active), 0);
    chk("arst_low_ms", 32'(low_ms), 0);
    chk("arst_init_ready", 32'(init_ready), 0);
    chk("arst_err_short", 32'(err_short), 0);
    chk("arst_err_long", 32'(err_long), 0);
    chk("arst_pulse_done", 32'(pulse_done), 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    chk("arst_rel_act_early", 32'(rst_active), 0);
    wait_clk(1);
    chk("arst_rel_act", 32'(rst_active), 1);
    repeat (67) @(posedge clk);
    #1 din = 1'b1;
    push(70, 10'd7, 0, 0);
    wait_clk(60);
    chk("arst_final_ready", 32'(init_ready), 1);

    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
